// File: rtl/stage4_dmem_controller.sv
// Data-memory request controller: one load/store at a time on the generic bus,
// byte-lane steering, load extension, misalignment flag and fence.i sequencing.
module stage4_dmem_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ren,
  input  logic              wen,
  input  logic              ifence,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [2:0]        load_type,
  output logic              lsc_ready,
  output logic [DATA_W-1:0] dload_ext,
  output logic              mal_addr,
  output logic              bus_error,
  output logic              fence_stall,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_ren,
  output logic              bus_wen,
  output logic [3:0]        bus_byte_en,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_busy,
  input  logic              bus_err,
  output logic              dflush,
  input  logic              dflush_done,
  output logic              iclear,
  input  logic              iclear_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP,
    S_FLUSH_D,
    S_CLR_I
  } state_t;

  state_t            r_state;
  logic [2:0]        r_ltype;
  logic [1:0]        r_off;
  logic [DATA_W-1:0] r_dload_ext;
  logic              r_bus_error;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic              r_bus_ren;
  logic              r_bus_wen;
  logic [3:0]        r_bus_be;
  logic              r_dflush;
  logic              r_iclear;

  logic              w_req;
  logic              w_idle;
  logic              w_is_h;
  logic              w_is_w;
  logic [1:0]        w_off;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_sh;
  logic [DATA_W-1:0] w_ext;

  assign w_req  = ren | wen;
  assign w_idle = (r_state == S_IDLE);
  assign w_off  = addr[1:0];
  assign w_is_h = (load_type[1:0] == 2'b01);
  assign w_is_w = load_type[1];

  assign mal_addr    = w_req & ((w_is_h & w_off[0]) | (w_is_w & (w_off != 2'b00)));
  assign lsc_ready   = (r_state == S_RESP) | (w_idle & ~ren & ~wen & ~ifence) | (w_idle & mal_addr);
  assign fence_stall = (r_state == S_FLUSH_D) | (r_state == S_CLR_I) | (w_idle & ifence & ~w_req);

  always_comb begin
    w_be    = 4'b0001 << w_off;
    w_wdata = {4{store_data[7:0]}};
    if (w_is_w) begin
      w_be    = 4'b1111;
      w_wdata = store_data;
    end else if (w_is_h) begin
      w_be    = 4'b0011 << w_off;
      w_wdata = {2{store_data[15:0]}};
    end
  end

  // Load data is right-aligned by the captured byte offset before extension.
  assign w_sh = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = bus_rdata;
    case (r_ltype)
      3'b000:  w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b100:  w_ext = {24'b0, w_sh[7:0]};
      3'b001:  w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b101:  w_ext = {16'b0, w_sh[15:0]};
      default: w_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_ltype     <= '0;
      r_off       <= '0;
      r_dload_ext <= '0;
      r_bus_error <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_ren   <= 1'b0;
      r_bus_wen   <= 1'b0;
      r_bus_be    <= '0;
      r_dflush    <= 1'b0;
      r_iclear    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A memory request wins over a simultaneous ifence.
          if (w_req) begin
            if (!mal_addr) begin
              r_ltype     <= load_type;
              r_off       <= w_off;
              r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              r_bus_wdata <= w_wdata;
              r_bus_ren   <= ren;
              r_bus_wen   <= ~ren & wen;
              r_bus_be    <= w_be;
              r_state     <= S_ACCESS;
            end
          end else if (ifence) begin
            r_dflush <= 1'b1;
            r_state  <= S_FLUSH_D;
          end
        end
        S_ACCESS: begin
          if (!bus_busy) begin
            r_dload_ext <= w_ext;
            r_bus_error <= bus_err;
            r_bus_ren   <= 1'b0;
            r_bus_wen   <= 1'b0;
            r_bus_be    <= '0;
            r_state     <= S_RESP;
          end
        end
        S_RESP: r_state <= S_IDLE;
        S_FLUSH_D: begin
          if (dflush_done) begin
            r_dflush <= 1'b0;
            r_iclear <= 1'b1;
            r_state  <= S_CLR_I;
          end
        end
        S_CLR_I: begin
          if (iclear_done) begin
            r_iclear <= 1'b0;
            r_state  <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dload_ext   = r_dload_ext;
  assign bus_error   = r_bus_error;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_ren     = r_bus_ren;
  assign bus_wen     = r_bus_wen;
  assign bus_byte_en = r_bus_be;
  assign dflush      = r_dflush;
  assign iclear      = r_iclear;

endmodule

// File: tb/tb_stage4_dmem_controller.sv
// Scoreboard bench for stage4_dmem_controller: directed cases, random traffic
// against an arithmetic reference model, and an asynchronous reset mid-access.
module tb_stage4_dmem_controller;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ren = 1'b0, wen = 1'b0, ifence = 1'b0;
  logic [31:0] addr = '0, store_data = '0;
  logic [2:0]  load_type = '0;
  logic        lsc_ready, mal_addr, bus_error, fence_stall;
  logic [31:0] dload_ext, bus_addr, bus_wdata;
  logic        bus_ren, bus_wen;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_rdata;
  logic        bus_busy, bus_err;
  logic        dflush, dflush_done, iclear, iclear_done;

  stage4_dmem_controller #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .ifence(ifence),
    .addr(addr), .store_data(store_data), .load_type(load_type),
    .lsc_ready(lsc_ready), .dload_ext(dload_ext), .mal_addr(mal_addr),
    .bus_error(bus_error), .fence_stall(fence_stall), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ren(bus_ren), .bus_wen(bus_wen),
    .bus_byte_en(bus_byte_en), .bus_rdata(bus_rdata), .bus_busy(bus_busy),
    .bus_err(bus_err), .dflush(dflush), .dflush_done(dflush_done),
    .iclear(iclear), .iclear_done(iclear_done)
  );

  always #5 CLK = ~CLK;

  // kind: 0 load, 1 store, 2 misaligned, 3 fence
  typedef struct {
    int          kind;
    logic [31:0] dload;
    logic        err;
    int          stall;
  } exp_t;

  typedef struct {
    logic        is_wr;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          waitc;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    dplan = 1, iplan = 1;
  int    stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
  endtask

  function automatic int unsigned acc_size(input logic [2:0] lt);
    case (lt[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  // Reference load extension: shift down, mask to the access width, then
  // subtract 2^width when signed and the value is in the upper half.
  function automatic logic [31:0] ext_model(input logic [31:0] rd, input int unsigned off,
                                            input logic [2:0] lt);
    longint sh, mask, v;
    if (acc_size(lt) == 4) return rd;
    sh   = longint'(rd) >> (8 * off);
    mask = (longint'(1) << (8 * acc_size(lt))) - 1;
    v    = sh & mask;
    if (!lt[2] && v >= (mask + 1) / 2) v = v - (mask + 1);
    return v[31:0];
  endfunction

  task automatic wait_ready();
    int k = 0;
    forever begin
      @(negedge CLK);
      if (lsc_ready) break;
      k++;
      if (k >= 200) begin
        n_checks++;
        $display("FAIL lsc_ready_timeout: got 0 expected 1 at %0t", $time);
        summary();
        $finish;
      end
    end
    @(posedge CLK); #1;
    ren = 1'b0; wen = 1'b0; ifence = 1'b0;
  endtask

  task automatic issue_mem(input bit wr, input logic [2:0] lt, input logic [31:0] a,
                           input logic [31:0] sd, input int w, input logic [31:0] rd,
                           input bit er);
    int unsigned sz, off;
    exp_t  e;
    plan_t p;
    sz  = acc_size(lt);
    off = a % 4;
    if ((a % sz) != 0) begin
      e.kind = 2;
      e.dload = '0; e.err = 1'b0; e.stall = 0;
    end else begin
      e.kind  = wr ? 1 : 0;
      e.dload = ext_model(rd, off, lt);
      e.err   = er;
      e.stall = 0;
      p.is_wr = wr;
      p.baddr = a - off;
      p.be    = 4'(((1 << sz) - 1) << off);
      if (sz == 1)      p.wdata = sd[7:0] * 32'h0101_0101;
      else if (sz == 2) p.wdata = sd[15:0] * 32'h0001_0001;
      else              p.wdata = sd;
      p.rdata = rd;
      p.err   = er;
      p.waitc = w;
      plan_q.push_back(p);
    end
    exp_q.push_back(e);
    ren = !wr; wen = wr; addr = a; store_data = sd; load_type = lt;
    wait_ready();
  endtask

  task automatic issue_fence(input int d, input int i);
    exp_t e;
    dplan = d; iplan = i;
    e.kind = 3; e.dload = '0; e.err = 1'b0; e.stall = 1 + d + i;
    exp_q.push_back(e);
    ifence = 1'b1;
    wait_ready();
  endtask

  // Response monitor: a held request together with lsc_ready is a completion.
  exp_t me;
  always @(negedge CLK) begin
    if (fence_stall) stall_cnt++;
    if (dflush || iclear) chk("dflush_iclear_exclusive", 32'(dflush & iclear), 0);
    if (nRST && lsc_ready && (ren || wen || ifence)) begin
      if (exp_q.size() == 0) chk("unexpected_response", 1, 0);
      else begin
        me = exp_q.pop_front();
        case (me.kind)
          0: begin
            chk("load_data", dload_ext, me.dload);
            chk("load_bus_error", 32'(bus_error), 32'(me.err));
            chk("load_mal_addr", 32'(mal_addr), 0);
          end
          1: chk("store_bus_error", 32'(bus_error), 32'(me.err));
          2: begin
            chk("mal_addr_flag", 32'(mal_addr), 1);
            chk("mal_no_strobe", 32'(bus_ren | bus_wen), 0);
          end
          default: begin
            chk("fence_stall_cycles", stall_cnt, me.stall);
            chk("fence_stall_in_resp", 32'(fence_stall), 0);
            stall_cnt = 0;
          end
        endcase
      end
    end
  end

  // Bus responder: pops a plan at the first strobe cycle, checks the request
  // fields, and holds busy for the planned number of wait cycles.
  plan_t cur;
  bit    act = 1'b0;
  int    cnt = 0, strobes = 0;
  always @(negedge CLK) begin
    if (bus_ren || bus_wen) begin
      if (!act) begin
        act = 1'b1;
        strobes = 0;
        if (plan_q.size() == 0) begin
          chk("unexpected_bus_access", 1, 0);
          cur.is_wr = bus_wen; cur.rdata = '0; cur.err = 1'b0; cur.waitc = 0;
          cur.baddr = '0; cur.be = '0; cur.wdata = '0;
        end else begin
          cur = plan_q.pop_front();
          chk("bus_wen_dir", 32'(bus_wen), 32'(cur.is_wr));
          chk("bus_ren_dir", 32'(bus_ren), 32'(!cur.is_wr));
          chk("bus_addr", bus_addr, cur.baddr);
          chk("bus_byte_en", 32'(bus_byte_en), 32'(cur.be));
          if (cur.is_wr) chk("bus_wdata", bus_wdata, cur.wdata);
        end
        cnt = cur.waitc;
      end
      strobes++;
      bus_rdata = cur.rdata;
      bus_err   = cur.err;
      bus_busy  = (cnt > 0);
      if (cnt > 0) cnt--;
    end else begin
      if (act && nRST) chk("strobe_cycles", strobes, cur.waitc + 1);
      act = 1'b0;
      bus_busy  = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      bus_err   = 1'($urandom_range(0, 1));
    end
  end

  // Cache responder; done strobes outside their own request are random noise.
  int dc = 0, ic = 0;
  always @(negedge CLK) begin
    if (dflush) begin dc++; dflush_done = (dc >= dplan); end
    else begin dc = 0; dflush_done = 1'($urandom_range(0, 1)); end
    if (iclear) begin ic++; iclear_done = (ic >= iplan); end
    else begin ic = 0; iclear_done = 1'($urandom_range(0, 1)); end
  end

  logic [2:0] ltl[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] lts[3] = '{3'd0, 3'd1, 3'd2};

  initial begin
    plan_t p;
    exp_t  e;
    int    r;
    bit    wr;
    logic [2:0] lt;
    bit    seen;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_lsc_ready", 32'(lsc_ready), 1);
    chk("rst_dload_ext", dload_ext, 0);
    chk("rst_bus_error", 32'(bus_error), 0);
    chk("rst_bus_ren", 32'(bus_ren), 0);
    chk("rst_bus_wen", 32'(bus_wen), 0);
    chk("rst_bus_byte_en", 32'(bus_byte_en), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_dflush", 32'(dflush), 0);
    chk("rst_iclear", 32'(iclear), 0);
    chk("rst_fence_stall", 32'(fence_stall), 0);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK); #1;

    issue_mem(0, 3'd2, 32'h1000, 0, 1, 32'hDEAD_BEEF, 0);
    issue_mem(0, 3'd0, 32'h2003, 0, 0, 32'h80FF_0000, 0);
    issue_mem(0, 3'd4, 32'h2003, 0, 2, 32'h80FF_0000, 0);
    issue_mem(0, 3'd1, 32'h2002, 0, 0, 32'h80FF_0000, 0);
    issue_mem(1, 3'd1, 32'h3002, 32'h1234_ABCD, 2, 32'h5555_5555, 0);
    issue_mem(0, 3'd2, 32'h1002, 0, 0, 0, 0);
    issue_mem(0, 3'd2, 32'h1000, 0, 0, 32'h1234_5678, 1);
    issue_fence(3, 2);
    ifence = 1'b1;
    issue_mem(0, 3'd2, 32'h0040, 0, 1, 32'hA5A5_0F0F, 0);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) issue_fence($urandom_range(1, 4), $urandom_range(1, 3));
      else if (r == 1) begin
        @(negedge CLK);
        chk("idle_lsc_ready", 32'(lsc_ready), 1);
        chk("idle_no_strobe", 32'(bus_ren | bus_wen), 0);
        @(posedge CLK); #1;
      end else begin
        wr = (r >= 7);
        lt = wr ? lts[$urandom_range(0, 2)] : ltl[$urandom_range(0, 4)];
        issue_mem(wr, lt, 32'h4000 + $urandom_range(0, 63), $urandom,
                  $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0));
      end
    end

    // Asynchronous reset while the bus is busy; the request is then re-run.
    p.is_wr = 1'b0; p.baddr = 32'h5000; p.be = 4'hF; p.wdata = '0;
    p.rdata = 32'h1111_2222; p.err = 1'b0; p.waitc = 40;
    plan_q.push_back(p);
    ren = 1'b1; addr = 32'h5000; load_type = 3'd2;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      if (bus_ren) begin seen = 1'b1; break; end
    end
    chk("pre_reset_strobe", 32'(seen), 1);
    repeat (2) @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_bus_ren", 32'(bus_ren), 0);
    chk("mid_rst_byte_en", 32'(bus_byte_en), 0);
    chk("mid_rst_bus_addr", bus_addr, 0);
    chk("mid_rst_dload_ext", dload_ext, 0);
    chk("mid_rst_lsc_ready", 32'(lsc_ready), 0);
    plan_q.delete();
    repeat (2) @(negedge CLK);
    p.rdata = 32'hCAFE_F00D; p.waitc = 1;
    plan_q.push_back(p);
    e.kind = 0; e.dload = 32'hCAFE_F00D; e.err = 1'b0; e.stall = 0;
    exp_q.push_back(e);
    nRST = 1'b1;
    @(posedge CLK); #1;
    chk("restart_strobe_cycle1", 32'(bus_ren), 1);
    wait_ready();

    repeat (5) @(posedge CLK);
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("plan_queue_drained", plan_q.size(), 0);
    summary();
    $finish;
  end

endmodule
